// File: rtl/comparator_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package comparator_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COMPARE = 1'b1
  } state_t;

  // Result encoding, ordered {lt, gt, eq}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/comparator1bit.sv
// Combinational 1-bit magnitude compare slice: exactly one of lt/gt/eq is high.
module comparator1bit (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic gt,
  output logic eq
);

  assign lt = ~a & b;
  assign gt = a & ~b;
  assign eq = ~(a ^ b);

endmodule

// File: rtl/comparator_serial.sv
// Bit-serial magnitude comparator: walks latched operands MSB-first through one
// 1-bit slice, stopping at the first differing bit. Signed and unsigned modes.
module comparator_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IW-1:0]    idx;
  logic             done_q;
  logic [2:0]       res_q;

  logic             load;
  logic             step;
  logic             decide;
  logic             s_lt;
  logic             s_gt;
  logic             s_eq;
  logic             swap;
  logic [2:0]       res_n;

  comparator1bit u_slice (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .lt (s_lt),
    .gt (s_gt),
    .eq (s_eq)
  );

  // In two's complement the sign bit carries negative weight, so a set MSB
  // means "smaller": swap the slice's lt/gt on the sign bit only.
  assign swap = signed_q && (idx == IDX_MSB);

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    decide  = 1'b0;
    res_n   = res_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (!s_eq) begin
          decide  = 1'b1;
          state_n = ST_IDLE;
          res_n   = swap ? {s_gt, s_lt, 1'b0} : {s_lt, s_gt, 1'b0};
        end else if (idx == '0) begin
          decide  = 1'b1;
          state_n = ST_IDLE;
          res_n   = RES_EQ;
        end else begin
          step    = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= '0;
      done_q   <= 1'b0;
      res_q    <= RES_NONE;
    end else begin
      state  <= state_n;
      done_q <= decide;
      res_q  <= res_n;
      if (load) begin
        a_q      <= a;
        b_q      <= b;
        signed_q <= signed_mode;
        idx      <= IDX_MSB;
      end else if (step) begin
        idx <= idx - 1'b1;
      end
    end
  end

  assign busy   = (state == ST_COMPARE);
  assign done   = done_q;
  assign a_lt_b = res_q[2];
  assign a_gt_b = res_q[1];
  assign a_eq_b = res_q[0];

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench for comparator_serial (WIDTH=8): vector table plus
// hand-written handshake, back-to-back and reset-abort sequences.
module tb_comparator_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         a_lt_b;
  logic         a_gt_b;
  logic         a_eq_b;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         sm;
    int           exp_edge;
    logic [2:0]   exp_res;   // {lt, gt, eq}
  } vec_t;

  vec_t vecs[10];

  comparator_serial #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .a_lt_b      (a_lt_b),
    .a_gt_b      (a_gt_b),
    .a_eq_b      (a_eq_b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a compare and count negedges until done; edge k is the k-th
  // posedge after the start edge.
  task automatic run_compare(input logic [W-1:0] va, input logic [W-1:0] vb, input logic sm,
                             output int dec_edge, output int busy_cnt);
    @(negedge clk);
    a = va; b = vb; signed_mode = sm; start = 1'b1;
    dec_edge = -1;
    busy_cnt = 0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dec_edge = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic run_vec(input int i);
    int e;
    int bc;
    run_compare(vecs[i].va, vecs[i].vb, vecs[i].sm, e, bc);
    check($sformatf("v%0d_edge", i), 64'(e), 64'(vecs[i].exp_edge));
    check($sformatf("v%0d_res", i), {61'd0, a_lt_b, a_gt_b, a_eq_b}, {61'd0, vecs[i].exp_res});
    check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'(vecs[i].exp_edge));
    check($sformatf("v%0d_busy_at_done", i), {63'd0, busy}, 64'd0);
    @(negedge clk);
    check($sformatf("v%0d_done_one_cycle_and_hold", i),
          {60'd0, done, a_lt_b, a_gt_b, a_eq_b}, {60'd0, 1'b0, vecs[i].exp_res});
  endtask

  initial begin
    int e;
    int bc;
    int done_seen;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;

    vecs[0] = '{8'hA5, 8'h5A, 1'b0, 1, 3'b010};
    vecs[1] = '{8'h12, 8'h13, 1'b0, 8, 3'b100};
    vecs[2] = '{8'h3C, 8'h3C, 1'b0, 8, 3'b001};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 1, 3'b100};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1, 3'b010};
    vecs[5] = '{8'h7F, 8'h80, 1'b1, 1, 3'b010};
    vecs[6] = '{8'hFF, 8'hFE, 1'b1, 8, 3'b010};
    vecs[7] = '{8'h40, 8'h20, 1'b0, 2, 3'b010};
    vecs[8] = '{8'hF0, 8'hF8, 1'b1, 5, 3'b100};
    vecs[9] = '{8'h00, 8'h00, 1'b1, 8, 3'b001};

    // Power-up reset, then hold idle 5 cycles
    @(negedge clk);
    check("por_outputs", {59'd0, busy, done, a_lt_b, a_gt_b, a_eq_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("idle_hold_%0d", k), {59'd0, busy, done, a_lt_b, a_gt_b, a_eq_b}, 64'd0);
    end

    // Table-driven vectors
    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset mid-idle clears held result
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_reset_outputs", {59'd0, busy, done, a_lt_b, a_gt_b, a_eq_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start held through a compare: ignored while busy, accepted on the done cycle
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    a = 8'hFF; b = 8'h00;
    e = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        e = k;
        break;
      end
    end
    check("ignored_start_edge", 64'(e), 64'd8);
    check("ignored_start_res", {61'd0, a_lt_b, a_gt_b, a_eq_b}, {61'd0, 3'b100});
    @(negedge clk);
    check("b2b_accepted_busy", {62'd0, busy, done}, {62'd0, 2'b10});
    start = 1'b0;
    @(negedge clk);
    check("b2b_done_res", {60'd0, done, a_lt_b, a_gt_b, a_eq_b}, {60'd0, 4'b1010});

    // Reset after edge 3 aborts the compare
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", {59'd0, busy, done, a_lt_b, a_gt_b, a_eq_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_results_zero", {61'd0, a_lt_b, a_gt_b, a_eq_b}, 64'd0);
    run_compare(8'hA5, 8'h5A, 1'b0, e, bc);
    check("after_abort_edge", 64'(e), 64'd1);
    check("after_abort_res", {61'd0, a_lt_b, a_gt_b, a_eq_b}, {61'd0, 3'b010});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
